// File: rtl/mic_frame_sync.sv
// Aligns per-mic sample strobes into one multi-mic frame per sample period, zero-filling late lanes, into a show-ahead FIFO.
// Latency: last-lane valid at N -> frame_valid_out at N+2 (empty FIFO); timeout closes a frame TIMEOUT_CYCLES after first capture.
// Backpressure: valid/ready head; frames committed while the FIFO is full with no pop are dropped and overflow_out sticks.
// Optional: define MIC_FRAME_SYNC_TIMESTAMP_EN to add frame_timestamp_out (cycle count at the frame's first capture).
module mic_frame_sync #(
    parameter int WIDTH          = 16,
    parameter int NUM_MICS       = 3,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 2048
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic [NUM_MICS-1:0]              mic_valid_in,
    input  logic [NUM_MICS*WIDTH-1:0]        mic_data_in,
    output logic                             frame_valid_out,
    input  logic                             frame_ready_in,
    output logic [NUM_MICS*WIDTH-1:0]        frame_data_out,
    output logic [NUM_MICS-1:0]              frame_missing_out,
    output logic [$clog2(FIFO_DEPTH):0]      fifo_count_out,
`ifdef MIC_FRAME_SYNC_TIMESTAMP_EN
    output logic [31:0]                      frame_timestamp_out,
`endif
    output logic                             overflow_out
);
    localparam int LW = NUM_MICS * WIDTH;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [NUM_MICS-1:0] ALL_LANES = {NUM_MICS{1'b1}};

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_COMMIT} state_t;

    typedef struct packed {
`ifdef MIC_FRAME_SYNC_TIMESTAMP_EN
        logic [31:0]         ts;
`endif
        logic [NUM_MICS-1:0] miss;
        logic [LW-1:0]       dat;
    } entry_t;

    function automatic logic [LW-1:0] lane_bits(input logic [NUM_MICS-1:0] m);
        logic [LW-1:0] b;
        b = '0;
        for (int k = 0; k < NUM_MICS; k++) b[k*WIDTH +: WIDTH] = {WIDTH{m[k]}};
        return b;
    endfunction

    state_t              r_state, w_state_nxt;
    logic [NUM_MICS-1:0] r_cap_mask, w_cap_mask_nxt, r_pend_mask, w_pend_mask_nxt;
    logic [LW-1:0]       r_cap_dat, w_cap_dat_nxt, r_pend_dat, w_pend_dat_nxt;
    logic [TW-1:0]       r_timer, w_timer_nxt;
    logic [NUM_MICS-1:0] w_new, w_dup, w_start;
    logic                w_commit;

    assign w_new   = mic_valid_in & ~r_cap_mask;
    assign w_dup   = mic_valid_in & r_cap_mask;
    assign w_start = r_pend_mask | mic_valid_in;

    always_comb begin
        w_state_nxt     = r_state;
        w_cap_mask_nxt  = r_cap_mask;
        w_cap_dat_nxt   = r_cap_dat;
        w_pend_mask_nxt = r_pend_mask;
        w_pend_dat_nxt  = r_pend_dat;
        w_timer_nxt     = r_timer;
        w_commit        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|mic_valid_in) begin
                    w_cap_mask_nxt = mic_valid_in;
                    w_cap_dat_nxt  = mic_data_in & lane_bits(mic_valid_in);
                    w_timer_nxt    = '0;
                    w_state_nxt    = S_COLLECT;
                end
            end
            S_COLLECT: begin
                w_timer_nxt = (r_timer == '1) ? r_timer : r_timer + TW'(1);
                if (|w_dup) begin
                    // A repeat strobe means this lane has moved on: close now, carry the cycle's strobes forward.
                    w_pend_mask_nxt = mic_valid_in;
                    w_pend_dat_nxt  = mic_data_in & lane_bits(mic_valid_in);
                    w_state_nxt     = S_COMMIT;
                end else begin
                    w_cap_mask_nxt = r_cap_mask | w_new;
                    w_cap_dat_nxt  = (r_cap_dat & ~lane_bits(w_new)) | (mic_data_in & lane_bits(w_new));
                    if (((r_cap_mask | w_new) == ALL_LANES) || (r_timer == TW'(TIMEOUT_CYCLES - 1)))
                        w_state_nxt = S_COMMIT;
                end
            end
            S_COMMIT: begin
                w_commit        = 1'b1;
                w_cap_mask_nxt  = w_start;
                w_cap_dat_nxt   = (r_pend_dat & ~lane_bits(mic_valid_in)) | (mic_data_in & lane_bits(mic_valid_in));
                w_pend_mask_nxt = '0;
                w_pend_dat_nxt  = '0;
                w_timer_nxt     = '0;
                w_state_nxt     = (|w_start) ? S_COLLECT : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state     <= S_IDLE;
            r_cap_mask  <= '0;
            r_cap_dat   <= '0;
            r_pend_mask <= '0;
            r_pend_dat  <= '0;
            r_timer     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cap_mask  <= w_cap_mask_nxt;
            r_cap_dat   <= w_cap_dat_nxt;
            r_pend_mask <= w_pend_mask_nxt;
            r_pend_dat  <= w_pend_dat_nxt;
            r_timer     <= w_timer_nxt;
        end
    end

    entry_t         w_wr_entry;
    entry_t         r_mem [FIFO_DEPTH];
    entry_t         r_head;
    logic [PW-1:0]  r_rd_ptr, r_wr_ptr, w_rd_nxt;
    logic [CW-1:0]  r_count, w_cnt_nxt;
    logic           r_vld, r_ovf, w_full, w_pop, w_push;

`ifdef MIC_FRAME_SYNC_TIMESTAMP_EN
    logic [31:0] r_cyc, r_ts, r_pend_ts;
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_cyc     <= '0;
            r_ts      <= '0;
            r_pend_ts <= '0;
        end else begin
            r_cyc <= r_cyc + 32'd1;
            if (r_state == S_IDLE && |mic_valid_in) r_ts <= r_cyc;
            else if (r_state == S_COMMIT)           r_ts <= (|r_pend_mask) ? r_pend_ts : r_cyc;
            if (r_state == S_COLLECT && |w_dup)     r_pend_ts <= r_cyc;
        end
    end
    assign w_wr_entry.ts = r_ts;
    assign frame_timestamp_out = r_head.ts;
`endif
    assign w_wr_entry.miss = ~r_cap_mask;
    assign w_wr_entry.dat  = r_cap_dat;

    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_pop     = r_vld && frame_ready_in;
    assign w_push    = w_commit && (!w_full || w_pop);
    assign w_rd_nxt  = r_rd_ptr + PW'(w_pop);
    assign w_cnt_nxt = r_count + CW'(w_push) - CW'(w_pop);

    always_ff @(posedge clk_in) begin
        if (w_push) r_mem[r_wr_ptr] <= w_wr_entry;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_vld    <= 1'b0;
            r_ovf    <= 1'b0;
            r_head   <= '0;
        end else begin
            r_rd_ptr <= w_rd_nxt;
            r_wr_ptr <= r_wr_ptr + PW'(w_push);
            r_count  <= w_cnt_nxt;
            r_vld    <= (w_cnt_nxt != '0);
            if (w_commit && w_full && !w_pop) r_ovf <= 1'b1;
            // Head is re-registered every cycle; bypass the write when it lands at the new read slot.
            if (w_cnt_nxt == '0)                         r_head <= '0;
            else if (w_push && (r_wr_ptr == w_rd_nxt))   r_head <= w_wr_entry;
            else                                         r_head <= r_mem[w_rd_nxt];
        end
    end

    assign frame_valid_out   = r_vld;
    assign frame_data_out    = r_head.dat;
    assign frame_missing_out = r_head.miss;
    assign fifo_count_out    = r_count;
    assign overflow_out      = r_ovf;
endmodule

// File: tb/tb_mic_frame_sync.sv
// Directed bench for mic_frame_sync: alignment, timeout, duplicate close, FIFO full/overflow, mid-frame reset.
module tb_mic_frame_sync;
    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [2:0]  mic_valid_in = '0;
    logic [47:0] mic_data_in = '0;
    logic        frame_ready_in = 1'b0;
    logic        frame_valid_out;
    logic [47:0] frame_data_out;
    logic [2:0]  frame_missing_out;
    logic [2:0]  fifo_count_out;
    logic        overflow_out;
`ifdef MIC_FRAME_SYNC_TIMESTAMP_EN
    logic [31:0] frame_timestamp_out;
`endif

    int total = 0;
    int bad   = 0;

    mic_frame_sync #(.WIDTH(16), .NUM_MICS(3), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(2048)) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .mic_valid_in      (mic_valid_in),
        .mic_data_in       (mic_data_in),
        .frame_valid_out   (frame_valid_out),
        .frame_ready_in    (frame_ready_in),
        .frame_data_out    (frame_data_out),
        .frame_missing_out (frame_missing_out),
        .fifo_count_out    (fifo_count_out),
`ifdef MIC_FRAME_SYNC_TIMESTAMP_EN
        .frame_timestamp_out (frame_timestamp_out),
`endif
        .overflow_out      (overflow_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input logic [2:0] v, input logic [47:0] d);
        mic_valid_in = v;
        mic_data_in  = d;
        step();
        mic_valid_in = '0;
        mic_data_in  = '0;
    endtask

    // All three lanes in one cycle; returns once the pushed frame is visible.
    task automatic send_full(input logic [47:0] d);
        drive(3'b111, d);
        step();
        step();
    endtask

    function automatic logic [47:0] fd(input int i);
        return {16'(i * 16 + 2), 16'(i * 16 + 1), 16'(i * 16)};
    endfunction

    initial begin
        #2 rst_in = 1'b0;
        #20;
        chk("rst_valid", 64'(frame_valid_out), 64'd0);
        chk("rst_data", 64'(frame_data_out), 64'd0);
        chk("rst_missing", 64'(frame_missing_out), 64'd0);
        chk("rst_count", 64'(fifo_count_out), 64'd0);
        chk("rst_overflow", 64'(overflow_out), 64'd0);
        #1 rst_in = 1'b1;
        step();
        step();

        // Staggered lanes, consumer always ready
        frame_ready_in = 1'b1;
        drive(3'b001, 48'h0000_0000_1111);
        drive(3'b010, 48'h0000_2222_0000);
        drive(3'b100, 48'h3333_0000_0000);
        chk("t1_valid_n1", 64'(frame_valid_out), 64'd0);
        step();
        chk("t1_valid_n2", 64'(frame_valid_out), 64'd1);
        chk("t1_data", 64'(frame_data_out), 64'h3333_2222_1111);
        chk("t1_missing", 64'(frame_missing_out), 64'd0);
        chk("t1_count", 64'(fifo_count_out), 64'd1);
        step();
        chk("t1_popped_valid", 64'(frame_valid_out), 64'd0);
        chk("t1_popped_count", 64'(fifo_count_out), 64'd0);

        // Lane 2 silent: timeout closes the frame
        frame_ready_in = 1'b0;
        drive(3'b001, 48'h0000_0000_AAAA);
        drive(3'b010, 48'h0000_BBBB_0000);
        repeat (2047) step();
        chk("t2_valid_early", 64'(frame_valid_out), 64'd0);
        step();
        chk("t2_valid", 64'(frame_valid_out), 64'd1);
        chk("t2_data", 64'(frame_data_out), 64'h0000_BBBB_AAAA);
        chk("t2_missing", 64'(frame_missing_out), 64'b100);
        frame_ready_in = 1'b1;
        step();
        frame_ready_in = 1'b0;
        chk("t2_count_after_pop", 64'(fifo_count_out), 64'd0);

        // Duplicate lane-0 strobe 15 cycles later closes frame 1
        drive(3'b001, 48'h0000_0000_0005);
        repeat (14) step();
        drive(3'b001, 48'h0000_0000_0020);
        step();
        chk("t3_f1_valid", 64'(frame_valid_out), 64'd1);
        chk("t3_f1_data", 64'(frame_data_out), 64'h0000_0000_0005);
        chk("t3_f1_missing", 64'(frame_missing_out), 64'b110);
        drive(3'b010, 48'h0000_0121_0000);
        drive(3'b100, 48'h0122_0000_0000);
        step();
        chk("t3_count", 64'(fifo_count_out), 64'd2);
        frame_ready_in = 1'b1;
        step();
        chk("t3_f2_data", 64'(frame_data_out), 64'h0122_0121_0020);
        chk("t3_f2_missing", 64'(frame_missing_out), 64'd0);
        step();
        frame_ready_in = 1'b0;
        chk("t3_count_end", 64'(fifo_count_out), 64'd0);

        // Full FIFO: commit and pop in the same cycle
        for (int i = 1; i <= 4; i++) send_full(fd(i));
        chk("t4_count_full", 64'(fifo_count_out), 64'd4);
        drive(3'b111, fd(5));
        step();
        frame_ready_in = 1'b1;
        step();
        frame_ready_in = 1'b0;
        chk("t4_count_same", 64'(fifo_count_out), 64'd4);
        chk("t4_no_overflow", 64'(overflow_out), 64'd0);
        for (int i = 2; i <= 5; i++) begin
            chk($sformatf("t4_pop%0d", i), 64'(frame_data_out), 64'(fd(i)));
            frame_ready_in = 1'b1;
            step();
            frame_ready_in = 1'b0;
        end
        chk("t4_count_end", 64'(fifo_count_out), 64'd0);

        // Five frames into depth 4 with no consumer
        for (int i = 1; i <= 5; i++) begin
            send_full(fd(10 + i));
            if (i == 4) chk("t5_ovf_before", 64'(overflow_out), 64'd0);
        end
        chk("t5_count", 64'(fifo_count_out), 64'd4);
        chk("t5_overflow", 64'(overflow_out), 64'd1);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("t5_pop%0d", i), 64'(frame_data_out), 64'(fd(10 + i)));
            frame_ready_in = 1'b1;
            step();
            frame_ready_in = 1'b0;
        end
        chk("t5_count_end", 64'(fifo_count_out), 64'd0);
        chk("t5_overflow_sticky", 64'(overflow_out), 64'd1);

        // Reset mid-COLLECT with two frames buffered
        send_full(fd(20));
        send_full(fd(21));
        chk("t6_count_pre", 64'(fifo_count_out), 64'd2);
        drive(3'b001, 48'h0000_0000_7777);
        #3 rst_in = 1'b0;
        #1;
        chk("t6_rst_valid", 64'(frame_valid_out), 64'd0);
        chk("t6_rst_count", 64'(fifo_count_out), 64'd0);
        chk("t6_rst_data", 64'(frame_data_out), 64'd0);
        chk("t6_rst_overflow", 64'(overflow_out), 64'd0);
        step();
        rst_in = 1'b1;
        step();
        frame_ready_in = 1'b1;
        drive(3'b001, 48'h0000_0000_4444);
        drive(3'b010, 48'h0000_5555_0000);
        drive(3'b100, 48'h6666_0000_0000);
        step();
        chk("t6_valid", 64'(frame_valid_out), 64'd1);
        chk("t6_data", 64'(frame_data_out), 64'h6666_5555_4444);
        chk("t6_missing", 64'(frame_missing_out), 64'd0);
        chk("t6_count", 64'(fifo_count_out), 64'd1);
        step();
        frame_ready_in = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
